// File: rtl/cbf_pkg.sv
// Shared definitions for the code-block-fusion source/target pair:
// step encoding and the hoisted arithmetic both models evaluate.
package cbf_pkg;

   localparam int STEP_W = 3;
   localparam int CALC_W = 32;

   typedef enum logic [STEP_W-1:0] {
      ST_INIT   = 3'd0,
      ST_HOIST  = 3'd1,
      ST_BRANCH = 3'd2,
      ST_LOAD   = 3'd3,
      ST_DONE   = 3'd4
   } step_e;

   // (2*(e0+1)) * ((e1-1) mod 2); callers truncate to their width.
   function automatic logic [CALC_W-1:0] hoist_a(
      input logic [CALC_W-1:0] e0,
      input logic [CALC_W-1:0] e1
   );
      logic [CALC_W-1:0] dbl;
      logic [CALC_W-1:0] par;
      dbl = (e0 + CALC_W'(1)) << 1;
      par = (e1 - CALC_W'(1)) % CALC_W'(2);
      return dbl * par;
   endfunction

endpackage

// File: rtl/cbf_elem_mux.sv
// Element select from a packed array; yields zero when the
// index lies past the last element.
module cbf_elem_mux #(
   parameter int DATA_W  = 1,
   parameter int ARR_LEN = 2,
   parameter int SEL_W   = 1
) (
   input  logic [ARR_LEN*DATA_W-1:0] arr,
   input  logic [SEL_W-1:0]          sel,
   output logic [DATA_W-1:0]         elem
);

   always_comb begin
      elem = '0;
      for (int k = 0; k < ARR_LEN; k++) begin
         if (int'(sel) == k) begin
            elem = arr[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/target_codeblock.sv
// Optimized code block: hoisted a-expression, fused indexed load,
// stepped by a stutter-aware FSM for trace comparison.
module target_codeblock
   import cbf_pkg::*;
#(
   parameter int DATA_W  = 1,
   parameter int ARR_LEN = 2,
   parameter int IDX_W   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stutter_in,
   input  logic [IDX_W-1:0]          j,
   input  logic [IDX_W-1:0]          arr_size,
   input  logic [ARR_LEN*DATA_W-1:0] arr,
   output logic [DATA_W-1:0]         a,
   output logic [DATA_W-1:0]         b,
   output logic                      stutter,
   output logic                      done,
   output logic [STEP_W-1:0]         step
);

   step_e state_q;
   step_e state_d;

   logic [IDX_W-1:0]          j_q;
   logic [IDX_W-1:0]          size_q;
   logic [IDX_W-1:0]          sel_q;
   logic [ARR_LEN*DATA_W-1:0] arr_q;

   logic [DATA_W-1:0] e1;
   logic [DATA_W-1:0] elem;

   logic latch_en;
   logic a_en;
   logic sel_en;
   logic b_en;

   // e1 reads as zero when the array has a single element
   cbf_elem_mux #(
      .DATA_W  (DATA_W),
      .ARR_LEN (ARR_LEN),
      .SEL_W   (IDX_W)
   ) u_e1 (
      .arr  (arr_q),
      .sel  (IDX_W'(1)),
      .elem (e1)
   );

   cbf_elem_mux #(
      .DATA_W  (DATA_W),
      .ARR_LEN (ARR_LEN),
      .SEL_W   (IDX_W)
   ) u_load (
      .arr  (arr_q),
      .sel  (sel_q),
      .elem (elem)
   );

   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      a_en     = 1'b0;
      sel_en   = 1'b0;
      b_en     = 1'b0;
      if (!stutter_in) begin
         case (state_q)
            ST_INIT: begin
               state_d  = ST_HOIST;
               latch_en = 1'b1;
            end
            ST_HOIST: begin
               state_d = ST_BRANCH;
               a_en    = 1'b1;
            end
            ST_BRANCH: begin
               state_d = ST_LOAD;
               sel_en  = 1'b1;
            end
            ST_LOAD: begin
               state_d = ST_DONE;
               b_en    = 1'b1;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         stutter <= 1'b0;
         j_q     <= '0;
         size_q  <= '0;
         arr_q   <= '0;
         sel_q   <= '0;
         a       <= '0;
         b       <= '0;
      end else begin
         stutter <= stutter_in;
         state_q <= state_d;
         if (latch_en) begin
            j_q    <= j;
            size_q <= arr_size;
            arr_q  <= arr;
         end
         if (a_en) begin
            a <= DATA_W'(hoist_a(CALC_W'(arr_q[DATA_W-1:0]),
                                 CALC_W'(e1)));
         end
         if (sel_en) begin
            sel_q <= (j_q <= size_q) ? j_q : size_q;
         end
         if (b_en) begin
            b <= elem;
         end
      end
   end

   assign step = state_q;
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_target_codeblock.sv
// Directed bench: vector table for plain runs, hand sequences
// for stutter, input-change and mid-run reset.
module tb_target_codeblock;

   logic clk;
   logic rst;
   logic stutter_in;
   logic [1:0]  j;
   logic [1:0]  arr_size;
   logic [15:0] arr;
   logic [3:0]  a;
   logic [3:0]  b;
   logic        stutter;
   logic        done;
   logic [2:0]  step;

   logic        s3_in;
   logic [1:0]  j3;
   logic [1:0]  size3;
   logic [11:0] arr3;
   logic [3:0]  a3;
   logic [3:0]  b3;
   logic        stutter3;
   logic        done3;
   logic [2:0]  step3;

   int total;
   int bad;

   typedef struct {
      logic [1:0]  j;
      logic [1:0]  sz;
      logic [15:0] arr;
      logic [3:0]  ea;
      logic [3:0]  eb;
   } vec_t;

   vec_t vt[5];

   target_codeblock #(
      .DATA_W  (4),
      .ARR_LEN (4),
      .IDX_W   (2)
   ) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .stutter_in (stutter_in),
      .j          (j),
      .arr_size   (arr_size),
      .arr        (arr),
      .a          (a),
      .b          (b),
      .stutter    (stutter),
      .done       (done),
      .step       (step)
   );

   target_codeblock #(
      .DATA_W  (4),
      .ARR_LEN (3),
      .IDX_W   (2)
   ) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .stutter_in (s3_in),
      .j          (j3),
      .arr_size   (size3),
      .arr        (arr3),
      .a          (a3),
      .b          (b3),
      .stutter    (stutter3),
      .done       (done3),
      .step       (step3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start(input logic [1:0] jj, input logic [1:0] ss,
                        input logic [15:0] aa);
      @(negedge clk);
      rst        = 1'b1;
      stutter_in = 1'b0;
      j          = jj;
      arr_size   = ss;
      arr        = aa;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_vec(input int i);
      start(vt[i].j, vt[i].sz, vt[i].arr);
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         chk($sformatf("v%0d step e%0d", i, e), int'(step), e);
         if (e == 2) chk($sformatf("v%0d a", i), int'(a), int'(vt[i].ea));
      end
      chk($sformatf("v%0d b", i), int'(b), int'(vt[i].eb));
      chk($sformatf("v%0d done", i), int'(done), 1);
      if (i == 0) begin
         chk("len3 a", int'(a3), 8);
         chk("len3 b", int'(b3), 0);
         chk("len3 done", int'(done3), 1);
      end
      @(negedge clk);
      chk($sformatf("v%0d a hold", i), int'(a), int'(vt[i].ea));
      chk($sformatf("v%0d b hold", i), int'(b), int'(vt[i].eb));
      chk($sformatf("v%0d step hold", i), int'(step), 4);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst        = 1'b1;
      stutter_in = 1'b0;
      j          = '0;
      arr_size   = '0;
      arr        = '0;
      s3_in      = 1'b0;
      j3         = 2'd3;
      size3      = 2'd3;
      arr3       = {4'd7, 4'd4, 4'd3};

      vt[0] = '{2'd1, 2'd2, {4'd9, 4'd7, 4'd4, 4'd3}, 4'd8, 4'd4};
      vt[1] = '{2'd3, 2'd2, {4'd9, 4'd7, 4'd5, 4'd3}, 4'd0, 4'd7};
      vt[2] = '{2'd0, 2'd0, {4'd1, 4'd2, 4'd2, 4'd15}, 4'd0, 4'd15};
      vt[3] = '{2'd3, 2'd3, {4'd12, 4'd11, 4'd0, 4'd6}, 4'd14, 4'd12};
      vt[4] = '{2'd2, 2'd1, {4'd5, 4'd4, 4'd8, 4'd2}, 4'd6, 4'd8};

      @(negedge clk);
      chk("rst a", int'(a), 0);
      chk("rst b", int'(b), 0);
      chk("rst step", int'(step), 0);
      chk("rst done", int'(done), 0);
      chk("rst stutter", int'(stutter), 0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // stutter held for three cycles while in BRANCH
      start(2'd1, 2'd2, {4'd9, 4'd7, 4'd4, 4'd3});
      @(negedge clk);
      @(negedge clk);
      chk("st step e2", int'(step), 2);
      chk("st stutter e2", int'(stutter), 0);
      stutter_in = 1'b1;
      for (int e = 3; e <= 5; e++) begin
         @(negedge clk);
         chk($sformatf("st step e%0d", e), int'(step), 2);
         chk($sformatf("st stutter e%0d", e), int'(stutter), 1);
      end
      stutter_in = 1'b0;
      @(negedge clk);
      chk("st step e6", int'(step), 3);
      chk("st stutter e6", int'(stutter), 0);
      @(negedge clk);
      chk("st b e7", int'(b), 4);
      chk("st done e7", int'(done), 1);
      chk("st a e7", int'(a), 8);

      // inputs change after latching
      start(2'd1, 2'd2, {4'd9, 4'd7, 4'd4, 4'd3});
      @(negedge clk);
      j   = 2'd3;
      arr = {4'd1, 4'd1, 4'd1, 4'd1};
      arr_size = 2'd0;
      for (int e = 2; e <= 4; e++) @(negedge clk);
      chk("chg a", int'(a), 8);
      chk("chg b", int'(b), 4);
      chk("chg done", int'(done), 1);

      // asynchronous reset while in LOAD with stutter high
      start(2'd1, 2'd2, {4'd9, 4'd7, 4'd4, 4'd3});
      for (int e = 1; e <= 3; e++) @(negedge clk);
      chk("ar step pre", int'(step), 3);
      stutter_in = 1'b1;
      @(negedge clk);
      chk("ar stutter pre", int'(stutter), 1);
      chk("ar a pre", int'(a), 8);
      rst = 1'b1;
      #1;
      chk("ar a", int'(a), 0);
      chk("ar b", int'(b), 0);
      chk("ar stutter", int'(stutter), 0);
      chk("ar done", int'(done), 0);
      chk("ar step", int'(step), 0);
      stutter_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) @(negedge clk);
      chk("ar a post", int'(a), 8);
      chk("ar b post", int'(b), 4);
      chk("ar done post", int'(done), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/target_codeblock.md
# target_codeblock

Optimized-program counterpart of the source code block in the code-block-fusion (cbf_ef) case study. It computes the same observable results `a` and `b` as the source program. The loop-invariant `a` expression is hoisted above the `j <= arr_size` branch, and the two branch arms are fused into a single indexed load. It sits beside the source block under the shared stutter-driven harness, so the asynchronous hyperproperty checker can compare their traces step by step.

## Interface
Parameters:
- `DATA_W`, 1, width of one array element and of outputs `a`, `b`
- `ARR_LEN`, 2, number of array elements
- `IDX_W`, 1, width of `j` and `arr_size`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stutter_in`  in  1  high = hold all computation state this cycle
- `j`  in  IDX_W  loop index (unsigned)
- `arr_size`  in  IDX_W  array bound (unsigned)
- `arr`  in  ARR_LEN*DATA_W  element k at bits [k*DATA_W +: DATA_W]
- `a`  out  DATA_W  hoisted arithmetic result (registered)
- `b`  out  DATA_W  loaded element (registered)
- `stutter`  out  1  `stutter_in` delayed one cycle
- `done`  out  1  high while in DONE
- `step`  out  3  current state encoding, for the monitor

## Operation
- Reset values (asynchronous, immediate on `rst`):
  - `a`, `b`, `stutter` = 0.
  - `step` = INIT (0), so `done` = 0.
  - Latched operands and `sel` = 0.
- `stutter` <= `stutter_in` every edge while out of reset, regardless of state.
- When `stutter_in` = 1, no state, operand, `sel`, `a` or `b` change.
- When `stutter_in` = 0, the FSM advances:
  - INIT (0) -> HOIST (1): latch `j`, `arr_size`, `arr` into internal registers. Later input changes are ignored until the next reset.
  - HOIST (1) -> BRANCH (2): `a` <= (2*(e0+1)) * ((e1-1) mod 2), truncated to DATA_W.
    - Arithmetic is unsigned, computed at DATA_W+2 bits.
    - Equivalent form: `a` = 2*(e0+1) if e1 is even (including e1 = 0, since 0-1 wraps to odd), else 0.
    - With ARR_LEN = 1, e1 reads as 0.
  - BRANCH (2) -> LOAD (3): `sel` <= (j <= arr_size) ? j : arr_size, unsigned compare.
  - LOAD (3) -> DONE (4): `b` <= element[`sel`]. If `sel` >= ARR_LEN, `b` <= 0.
  - DONE (4): terminal. Holds until reset; `done` = 1.
- Encodings 5–7 are unreachable. If entered, the FSM returns to INIT on the next non-stutter edge.

## Timing
- With no stutter:
  - `a` is valid after edge 2.
  - `b` is valid and `done` rises after edge 4.
  - This is the same number of non-stutter steps as the source block.
- Each stutter cycle delays all later events by exactly one edge.
- `stutter` lags `stutter_in` by one edge.
- `a` and `b` are written exactly once per run; their values never change after being written.
- Stutter asserted in the same cycle the FSM would leave a state: the transition does not happen.
- Reset mid-run: all outputs clear immediately, and the run restarts from INIT with fresh input latching once `rst` falls.

## Structure
- Shared package `cbf_pkg` holds:
  - the step enum (INIT, HOIST, BRANCH, LOAD, DONE) with the 3-bit encoding,
  - the STEP_W = 3 constant,
  - a function computing the hoisted `a` expression, so the source and target models share one definition.
- One natural sub-module, `cbf_elem_mux`: combinational element select from the latched array by `sel`, returning 0 when out of range. It is reused by the monitor.

## Test plan
- DATA_W=4, ARR_LEN=4, IDX_W=2; arr = {9,7,4,3} (e3..e0), j=1, arr_size=2, no stutter:
  - `a` = 8 after edge 2.
  - `b` = 4 and `done` = 1 after edge 4.
- Same parameters, arr = {9,7,5,3}, j=3, arr_size=2:
  - `a` = 0 (e1 odd).
  - `sel` = 2, so `b` = 7.
- Scenario 1 with `stutter_in` = 1 for 3 cycles while in BRANCH:
  - `step` holds at 2 for 3 edges.
  - `stutter` follows one edge late.
  - `b` = 4 after edge 7.
- ARR_LEN=3, IDX_W=2, j=3, arr_size=3: `sel` = 3 is out of range, so `b` = 0 and `done` = 1 after edge 4.
- Change `arr` and `j` after edge 1 of scenario 1: results stay `a` = 8, `b` = 4.
- Assert `rst` while `step` = 3:
  - `a`, `b`, `stutter`, `done` = 0 and `step` = 0 immediately, without waiting for a clock edge.
  - After release, scenario 1 values reappear after 4 edges.
